// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Ports:
//   clk, reset   : clock and synchronous active-high reset.
//   control_in   : MEM/WB control, [2] RegWrite, [1:0] wb_sel.
//   pc_4_in, data_in, alu_in : writeback value sources.
//   regdst_in    : destination register number.
//   raddr1/2     : decode read addresses; rdata1/2 are the read data.
//   wb_we, wb_dst, wb_data : effective writeback this cycle.
//   retire_cnt   : count of committed register writes (wraps).
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        control_in,
    input  logic [DATA_W-1:0] pc_4_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [ADDR_W-1:0] regdst_in,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retire_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [31:0]       r_retire_cnt;

    logic       w_regwrite;
    logic [1:0] w_sel;
    logic       w_we;

    assign w_regwrite = control_in[2];
    assign w_sel      = control_in[1:0];

    // The reserved selector falls back to the ALU value but never writes.
    always_comb begin
        wb_data = alu_in;
        case (w_sel)
            SEL_ALU: wb_data = alu_in;
            SEL_MEM: wb_data = data_in;
            SEL_PC:  wb_data = pc_4_in;
            default: wb_data = alu_in;
        endcase
    end

    assign w_we = w_regwrite & (w_sel != SEL_RSV)
                & (regdst_in != '0) & ~reset;

    assign wb_we      = w_we;
    assign wb_dst     = w_we ? regdst_in : '0;
    assign retire_cnt = r_retire_cnt;

    // Register 0 is hardwired; reset masks reads so consumers see zero.
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        if (reset || a == '0)
            v = '0;
        else if (BYPASS != 0 && w_we && a == regdst_in)
            v = wb_data;
        else
            v = r_regs[a];
        return v;
    endfunction

    always_comb rdata1 = f_read(raddr1);
    always_comb rdata2 = f_read(raddr2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_retire_cnt <= '0;
        end else if (w_we) begin
            r_regs[regdst_in] <= wb_data;
            r_retire_cnt      <= r_retire_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: two instances (bypass on/off)
// share stimulus; a reference model predicts every cycle's outputs.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  control_in = 3'b001;
    logic [31:0] pc_4_in = '0;
    logic [31:0] data_in = '0;
    logic [31:0] alu_in = '0;
    logic [4:0]  regdst_in = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;

    logic [31:0] rdata1, rdata2, wb_data, retire_cnt;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic [31:0] nb_rdata1, nb_rdata2, nb_wb_data, nb_retire_cnt;
    logic        nb_wb_we;
    logic [4:0]  nb_wb_dst;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .control_in(control_in),
        .pc_4_in(pc_4_in), .data_in(data_in), .alu_in(alu_in),
        .regdst_in(regdst_in), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .wb_we(wb_we),
        .wb_dst(wb_dst), .wb_data(wb_data), .retire_cnt(retire_cnt)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .control_in(control_in),
        .pc_4_in(pc_4_in), .data_in(data_in), .alu_in(alu_in),
        .regdst_in(regdst_in), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .wb_we(nb_wb_we),
        .wb_dst(nb_wb_dst), .wb_data(nb_wb_data),
        .retire_cnt(nb_retire_cnt)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] nb_rd1;
        logic [31:0] nb_rd2;
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural register contents and write count.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rdata1", rdata1, e.rd1);
            chk("rdata2", rdata2, e.rd2);
            chk("nb_rdata1", nb_rdata1, e.nb_rd1);
            chk("nb_rdata2", nb_rdata2, e.nb_rd2);
            chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            chk("wb_dst", {27'd0, wb_dst}, {27'd0, e.dst});
            chk("wb_data", wb_data, e.data);
            chk("retire_cnt", retire_cnt, e.cnt);
            chk("nb_retire_cnt", nb_retire_cnt, e.cnt);
        end
    end

    function automatic logic [31:0] m_read(
        input logic [4:0] a, input bit byp, input bit rst,
        input bit we, input logic [4:0] dst, input logic [31:0] wd
    );
        if (rst || a == 0) return 32'd0;
        if (byp && we && a == dst) return wd;
        return m_regs[a];
    endfunction

    task automatic drive(
        input bit rst, input logic [2:0] ctrl,
        input logic [31:0] pc4, input logic [31:0] din,
        input logic [31:0] alu, input logic [4:0] dst,
        input logic [4:0] ra1, input logic [4:0] ra2
    );
        exp_t e;
        logic [31:0] wd;
        bit we;
        @(posedge clk);
        #1;
        reset = rst; control_in = ctrl; pc_4_in = pc4;
        data_in = din; alu_in = alu; regdst_in = dst;
        raddr1 = ra1; raddr2 = ra2;
        if (ctrl[1:0] == 2'd1) wd = din;
        else if (ctrl[1:0] == 2'd2) wd = pc4;
        else wd = alu;
        we = ctrl[2] && ctrl[1:0] != 2'd3 && dst != 0 && !rst;
        e.rd1 = m_read(ra1, 1, rst, we, dst, wd);
        e.rd2 = m_read(ra2, 1, rst, we, dst, wd);
        e.nb_rd1 = m_read(ra1, 0, rst, we, dst, wd);
        e.nb_rd2 = m_read(ra2, 0, rst, we, dst, wd);
        e.we = we;
        e.dst = we ? dst : 5'd0;
        e.data = wd;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        // Model state after the coming edge.
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = '0;
        end else if (we) begin
            m_regs[dst] = wd;
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic bubble(input logic [4:0] ra1, input logic [4:0] ra2);
        drive(0, 3'b001, 0, 0, 0, 0, ra1, ra2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;

        drive(1, 3'b001, 0, 0, 0, 0, 5, 31);
        drive(1, 3'b001, 0, 0, 0, 0, 5, 31);
        bubble(5, 31);

        drive(0, 3'b100, 0, 0, 32'h11111111, 3, 3, 0);
        drive(0, 3'b101, 0, 32'h22222222, 0, 4, 3, 4);
        drive(0, 3'b110, 32'h00400008, 0, 0, 31, 4, 31);
        bubble(3, 4);
        bubble(31, 31);

        drive(0, 3'b101, 0, 32'hCAFEBABE, 0, 7, 7, 7);
        bubble(7, 7);

        drive(0, 3'b100, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
        bubble(0, 0);
        drive(0, 3'b111, 0, 0, 32'h99999999, 9, 9, 9);
        bubble(9, 9);
        drive(0, 3'b001, 0, 32'h77777777, 0, 10, 10, 10);
        bubble(10, 9);

        drive(0, 3'b100, 0, 0, 32'hA5A5A5A5, 2, 2, 6);
        drive(1, 3'b100, 0, 0, 32'h00000005, 6, 2, 6);
        drive(0, 3'b100, 0, 0, 32'h12345678, 8, 2, 6);
        bubble(8, 2);

        bubble(12, 12);
        @(posedge clk);
        #1;
        dut.r_retire_cnt = 32'hFFFFFFFF;
        dut_nb.r_retire_cnt = 32'hFFFFFFFF;
        m_cnt = 32'hFFFFFFFF;
        drive(0, 3'b100, 0, 0, 32'h0BADF00D, 12, 12, 1);
        bubble(12, 12);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] c;
            logic [4:0] d, a1, a2;
            bit r;
            r = ($urandom_range(0, 39) == 0);
            c = 3'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? d
                 : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? a1
                 : 5'($urandom_range(0, 31));
            drive(r, c, $urandom, $urandom, $urandom, d, a1, a2);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the writeback stage plus the architectural register file.
- Each cycle it takes the MEM/WB register outputs, selects the writeback value and commits it to a 32-entry register file.
- Serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Keeps a retired-write counter for debug and performance monitoring.

Parameters:
- DATA_W, 32, width of registers and data paths.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- BYPASS, 1, 1 = read ports see the value being written this cycle; 0 = read ports return the old stored value.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- control_in  input  3  MEM/WB control: [2] RegWrite, [1:0] wb_sel.
- pc_4_in  input  DATA_W  PC+4 of the retiring instruction.
- data_in  input  DATA_W  load data from memory.
- alu_in  input  DATA_W  ALU result.
- regdst_in  input  ADDR_W  destination register number.
- raddr1  input  ADDR_W  decode read address, port 1.
- raddr2  input  ADDR_W  decode read address, port 2.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- rdata2  output  DATA_W  read data, port 2 (combinational).
- wb_we  output  1  effective write enable this cycle, for forwarding and hazard logic.
- wb_dst  output  ADDR_W  effective destination this cycle.
- wb_data  output  DATA_W  selected writeback value this cycle.
- retire_cnt  output  32  count of committed register writes.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Writeback value selection (combinational):
  - wb_sel 00 -> alu_in.
  - wb_sel 01 -> data_in.
  - wb_sel 10 -> pc_4_in.
  - wb_sel 11 -> reserved; wb_data = alu_in and the write is suppressed.
- Effective write enable: wb_we = control_in[2] & (wb_sel != 11) & (regdst_in != 0) & ~reset.
- wb_dst = regdst_in when wb_we = 1, otherwise 0.
- Commit: on a rising clk edge with wb_we = 1, regs[regdst_in] <= wb_data. Latency is one edge; the value is stored at that edge.
- Register 0: reads always return 0 and is never written, including when regdst_in = 0 with RegWrite set.
- Reads are asynchronous. rdataN = 0 if raddrN == 0.
  - Otherwise, if BYPASS=1 and wb_we=1 and raddrN == regdst_in, rdataN = wb_data.
  - Otherwise rdataN = regs[raddrN].
- Both ports may address the same register; both then return identical data, including the bypassed value.
- retire_cnt increments by 1 on every edge where wb_we = 1 and wraps 0xFFFFFFFF -> 0 with no flag.
- Reset, on the rising edge with reset = 1:
  - All registers clear to 0 and retire_cnt clears to 0.
  - Any write presented in that cycle is dropped.
- While reset = 1:
  - rdata1 = rdata2 = 0, wb_we = 0, wb_dst = 0.
  - wb_data still follows the selection mux; it is don't-care to consumers.
- Reset asserted mid-stream discards the in-flight instruction. The first commit after deassertion is the instruction present in the first cycle with reset = 0.
- Idle/bubble: the MEM/WB reset control value 3'b001 (RegWrite=0, wb_sel=01) is a legal bubble. It causes no write and no counter change.
- No X propagation: an unwritten register reads 0 after reset.

Test Plan:
- Reset then read: hold reset 2 cycles, then read raddr1=5, raddr2=31 -> rdata1=rdata2=0, retire_cnt=0, wb_we=0.
- Select paths: control=3'b100, alu_in=0x11111111, regdst=3; then control=3'b101, data_in=0x22222222, regdst=4; then control=3'b110, pc_4_in=0x00400008, regdst=31 -> registers 3/4/31 read back 0x11111111 / 0x22222222 / 0x00400008; retire_cnt=3.
- Bypass: control=3'b101, data_in=0xCAFEBABE, regdst=7, raddr1=raddr2=7 in the same cycle -> rdata1=rdata2=0xCAFEBABE before the edge, and the same values after the edge. With BYPASS=0 the same stimulus returns the old value 0 before the edge.
- Register 0 and suppression:
  - control=3'b100, regdst=0, alu_in=0xFFFFFFFF -> r0 reads 0, wb_we=0, retire_cnt unchanged.
  - control=3'b111, regdst=9 -> r9 unchanged, no count.
  - Bubble control=3'b001 -> no write.
- Reset mid-operation: write r2=0xA5A5A5A5; then assert reset in the same cycle as a write of r6=0x5 -> after reset r2=0, r6=0, retire_cnt=0. The next write after deassertion commits and retire_cnt=1.
- Counter wrap: force retire_cnt to 0xFFFFFFFF (hierarchical deposit), then one valid write -> retire_cnt=0x00000000 and the register is updated normally.
